// File: rtl/gshare_pattern_table_if.sv
// Query, prediction, training and status signals of the gshare pattern table.
// The master modport is the fetch/resolve side, and the slave modport is the table.
interface gshare_pattern_table_if #(
  parameter int INDEX_LEN       = 10,
  parameter int GLOBAL_HIST_LEN = 10,
  parameter int PC_LEN          = 32
);
  logic                       is_stalling;
  logic                       query_valid;
  logic [PC_LEN-1:0]          query_pc;
  logic [GLOBAL_HIST_LEN-1:0] global_history;
  logic                       pred_valid;
  logic                       pred_taken;
  logic [1:0]                 pred_counter;
  logic [INDEX_LEN-1:0]       pred_index;
  logic                       update_enable;
  logic [INDEX_LEN-1:0]       update_index;
  logic                       update_taken;
  logic                       ready;

  modport master (
    output is_stalling, query_valid, query_pc, global_history,
    output update_enable, update_index, update_taken,
    input  pred_valid, pred_taken, pred_counter, pred_index, ready
  );

  modport slave (
    input  is_stalling, query_valid, query_pc, global_history,
    input  update_enable, update_index, update_taken,
    output pred_valid, pred_taken, pred_counter, pred_index, ready
  );
endinterface

// File: rtl/gshare_pattern_table.sv
// gshare pattern history table of 2-bit saturating counters. It returns a prediction one
// cycle after a query, trains through a latch/read-modify-write pair, and sweeps itself after reset.
module gshare_pattern_table #(
  parameter int INDEX_LEN       = 10,
  parameter int GLOBAL_HIST_LEN = 10,
  parameter int PC_LEN          = 32,
  parameter int PC_SHIFT        = 2
) (
  input logic                   clk,
  input logic                   reset,
  gshare_pattern_table_if.slave bus
);
  localparam int DEPTH = 2 ** INDEX_LEN;
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e               state;
  state_e               state_next;
  logic [INDEX_LEN-1:0] sweep_ptr;
  logic                 ready;
  logic                 init_we;
  logic                 active;

  logic [1:0]           table_mem [DEPTH];

  logic                 upd_valid;
  logic [INDEX_LEN-1:0] upd_index;
  logic                 upd_taken;

  logic [1:0]           b_old;
  logic [1:0]           b_new;
  logic                 b_we;

  logic [INDEX_LEN-1:0] query_idx;
  logic [1:0]           query_counter;

  logic                 pred_valid_q;
  logic                 pred_taken_q;
  logic [1:0]           pred_counter_q;
  logic [INDEX_LEN-1:0] pred_index_q;

  function automatic logic [1:0] saturate(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != 2'b11)
      res = ctr + 2'd1;
    else if (!taken && ctr != 2'b00)
      res = ctr - 2'd1;
    return res;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_next;
  end

  // NOTE: defaulting state_next before the case keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_INIT: if (sweep_ptr == '1) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  always_comb begin
    ready   = (state == ST_RUN);
    init_we = (state == ST_INIT);
  end

  // During INIT, the sweep writes one entry per edge and ignores the stall input.
  always_ff @(posedge clk) begin
    if (reset)        sweep_ptr <= '0;
    else if (init_we) sweep_ptr <= sweep_ptr + 1'b1;
  end

  assign active = ready && !bus.is_stalling;

  // gshare hash: the shorter history is zero-extended up to the index width.
  assign query_idx = bus.query_pc[PC_SHIFT +: INDEX_LEN]
                   ^ INDEX_LEN'(bus.global_history);

  // Stage B runs off the latched update. While stalled, it neither writes nor advances.
  assign b_old = table_mem[upd_index];
  assign b_new = saturate(b_old, upd_taken);
  assign b_we  = upd_valid && active;

  // A query that hits the entry stage B is writing sees the fresh counter.
  assign query_counter = (b_we && upd_index == query_idx) ? b_new : table_mem[query_idx];

  // NOTE: the counter array has no reset. The INIT sweep initialises it, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (init_we)   table_mem[sweep_ptr] <= CTR_WEAK_NT;
      else if (b_we) table_mem[upd_index] <= b_new;
    end
  end

  // Stage A. Updates that arrive during INIT or a stall are dropped, not queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid <= 1'b0;
      upd_index <= '0;
      upd_taken <= 1'b0;
    end else if (!ready) begin
      upd_valid <= 1'b0;
    end else if (!bus.is_stalling) begin
      upd_valid <= bus.update_enable;
      upd_index <= bus.update_index;
      upd_taken <= bus.update_taken;
    end
  end

  // The prediction register. The pred_* payload only moves on a valid query.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid_q   <= 1'b0;
      pred_taken_q   <= 1'b0;
      pred_counter_q <= '0;
      pred_index_q   <= '0;
    end else if (!ready) begin
      pred_valid_q <= 1'b0;
    end else if (active) begin
      pred_valid_q <= bus.query_valid;
      if (bus.query_valid) begin
        pred_index_q   <= query_idx;
        pred_counter_q <= query_counter;
        pred_taken_q   <= query_counter[1];
      end
    end
  end

  assign bus.pred_valid   = pred_valid_q;
  assign bus.pred_taken   = pred_taken_q;
  assign bus.pred_counter = pred_counter_q;
  assign bus.pred_index   = pred_index_q;
  assign bus.ready        = ready;
endmodule

// File: tb/tb_gshare_pattern_table.sv
// Bench for gshare_pattern_table with a 16-entry table. It uses directed vectors, reset
// and INIT sequences, and random traffic checked against an array-based behavioural model.
module tb_gshare_pattern_table;
  localparam int IL    = 4;
  localparam int GHL   = 4;
  localparam int PCL   = 32;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  gshare_pattern_table_if #(.INDEX_LEN(IL), .GLOBAL_HIST_LEN(GHL), .PC_LEN(PCL)) bus ();

  gshare_pattern_table #(
    .INDEX_LEN(IL), .GLOBAL_HIST_LEN(GHL), .PC_LEN(PCL), .PC_SHIFT(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: counters as plain integers, plus one pending training record.
  int m_tbl [DEPTH];
  int m_init_cycles;
  bit m_pend;
  int m_pidx;
  bit m_ptaken;
  bit m_pv;
  int m_pctr;
  int m_pidx_out;

  typedef struct {
    logic        qv;
    logic [31:0] pc;
    logic [3:0]  hist;
    logic        ue;
    logic [3:0]  ui;
    logic        ut;
    logic        stall;
    logic        ev;
    logic [1:0]  ec;
    logic [3:0]  ei;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int trained(input int ctr, input bit taken);
    if (taken) return (ctr < 3) ? ctr + 1 : 3;
    return (ctr > 0) ? ctr - 1 : 0;
  endfunction

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    int qidx;
    int nv;
    if (reset) begin
      m_init_cycles = 0;
      m_pend = 0; m_pv = 0; m_pctr = 0; m_pidx_out = 0;
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
    end else if (m_init_cycles < DEPTH) begin
      m_init_cycles++;
      m_pend = 0;
      m_pv = 0;
    end else if (!bus.is_stalling) begin
      qidx = ((int'(bus.query_pc) >>> 2) & (DEPTH - 1)) ^ int'(bus.global_history);
      nv = m_pend ? trained(m_tbl[m_pidx], m_ptaken) : 0;
      m_pv = bus.query_valid;
      if (bus.query_valid) begin
        m_pidx_out = qidx;
        m_pctr = (m_pend && m_pidx == qidx) ? nv : m_tbl[qidx];
      end
      if (m_pend) m_tbl[m_pidx] = nv;
      m_pend   = bus.update_enable;
      m_pidx   = int'(bus.update_index);
      m_ptaken = bus.update_taken;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit qv, input logic [31:0] pc, input logic [3:0] hist,
                       input bit ue, input logic [3:0] ui, input bit ut, input bit stall);
    bus.query_valid    = qv;
    bus.query_pc       = pc;
    bus.global_history = hist;
    bus.update_enable  = ue;
    bus.update_index   = ui;
    bus.update_taken   = ut;
    bus.is_stalling    = stall;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ready"},   int'(bus.ready),        int'(m_init_cycles >= DEPTH));
    check({tag, "_valid"},   int'(bus.pred_valid),   int'(m_pv));
    check({tag, "_counter"}, int'(bus.pred_counter), m_pctr);
    check({tag, "_taken"},   int'(bus.pred_taken),   int'(m_pctr >= 2));
    check({tag, "_index"},   int'(bus.pred_index),   m_pidx_out);
  endtask

  initial begin
    int cyc;
    checks = 0;
    errors = 0;

    //           qv  pc     hist ue ui   ut stall ev  ec  ei
    vecs[0]  = '{1, 32'h14, 3,  0, 0,  0, 0,    1, 1, 6};  // hash 5^3 = 6
    vecs[1]  = '{0, 32'h0,  0,  1, 6,  1, 0,    0, 1, 6};  // no query: payload holds
    vecs[2]  = '{1, 32'h18, 0,  1, 6,  1, 0,    1, 2, 6};  // bypass 1->2
    vecs[3]  = '{1, 32'h18, 0,  1, 6,  1, 0,    1, 3, 6};  // bypass 2->3
    vecs[4]  = '{1, 32'h18, 0,  0, 0,  0, 0,    1, 3, 6};  // saturate at 3
    vecs[5]  = '{1, 32'h18, 0,  0, 0,  0, 0,    1, 3, 6};
    vecs[6]  = '{0, 32'h0,  0,  1, 6,  0, 0,    0, 3, 6};
    vecs[7]  = '{0, 32'h0,  0,  1, 6,  0, 0,    0, 3, 6};
    vecs[8]  = '{0, 32'h0,  0,  1, 6,  0, 0,    0, 3, 6};
    vecs[9]  = '{0, 32'h0,  0,  1, 6,  0, 0,    0, 3, 6};
    vecs[10] = '{1, 32'h18, 0,  0, 0,  0, 0,    1, 0, 6};  // 4th not-taken, 0 stays 0
    vecs[11] = '{1, 32'h18, 0,  0, 0,  0, 0,    1, 0, 6};
    vecs[12] = '{1, 32'h20, 0,  1, 8,  1, 1,    1, 0, 6};  // stall: everything frozen
    vecs[13] = '{1, 32'h20, 0,  1, 8,  1, 1,    1, 0, 6};
    vecs[14] = '{1, 32'h20, 0,  1, 8,  1, 1,    1, 0, 6};
    vecs[15] = '{1, 32'h20, 0,  1, 8,  1, 0,    1, 1, 8};  // idx 8 untouched by stall
    vecs[16] = '{1, 32'h20, 0,  0, 0,  0, 0,    1, 2, 8};  // update accepted after stall
    vecs[17] = '{1, 32'h20, 0,  0, 0,  0, 0,    1, 2, 8};
    vecs[18] = '{1, 32'h14, 3,  0, 0,  0, 0,    1, 0, 6};
    vecs[19] = '{1, 32'h3C, 15, 0, 0,  0, 0,    1, 1, 0};  // 15^15 = 0
    vecs[20] = '{0, 32'h0,  0,  1, 0,  1, 0,    0, 1, 0};
    vecs[21] = '{1, 32'h3C, 15, 0, 0,  0, 1,    0, 1, 0};  // stage B held by stall
    vecs[22] = '{1, 32'h3C, 15, 0, 0,  0, 0,    1, 2, 0};  // held update lands, bypass

    // Reset, then ready rises exactly on the 17th cycle after release.
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    check("rst_valid",   int'(bus.pred_valid),   0);
    check("rst_counter", int'(bus.pred_counter), 0);
    check("rst_index",   int'(bus.pred_index),   0);
    reset = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      check("init_ready_low", int'(bus.ready), 0);
      drive(1, 32'h40, 0, 1, 4'(k), 1, k[0]);  // queries/updates/stalls during INIT
      step();
      check("init_pred_valid", int'(bus.pred_valid), 0);
    end
    check("init_ready_high", int'(bus.ready), 1);

    drive(1, 32'h40, 0, 0, 0, 0, 0);
    step();
    check("first_valid",   int'(bus.pred_valid),   1);
    check("first_counter", int'(bus.pred_counter), 1);
    check("first_taken",   int'(bus.pred_taken),   0);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].qv, vecs[i].pc, vecs[i].hist, vecs[i].ue, vecs[i].ui, vecs[i].ut,
            vecs[i].stall);
      step();
      check($sformatf("vec%0d_valid", i),   int'(bus.pred_valid),   int'(vecs[i].ev));
      check($sformatf("vec%0d_counter", i), int'(bus.pred_counter), int'(vecs[i].ec));
      check($sformatf("vec%0d_taken", i),   int'(bus.pred_taken),   int'(vecs[i].ec[1]));
      check($sformatf("vec%0d_index", i),   int'(bus.pred_index),   int'(vecs[i].ei));
    end

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 9) < 7), $urandom, 4'($urandom), $urandom_range(0, 1) == 1,
            4'($urandom), $urandom_range(0, 1) == 1, ($urandom_range(0, 4) == 0));
      step();
      check_model("rand");
    end

    // Mid-operation reset while stage B holds an update behind a stall.
    drive(0, 0, 0, 1, 3, 1, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("midrst_valid", int'(bus.pred_valid), 0);
    check("midrst_ready", int'(bus.ready), 0);
    reset = 1'b0;
    drive(0, 0, 0, 1, 3, 1, 0);  // training requests during INIT must be dropped
    cyc = 0;
    while (!bus.ready && cyc < 40) begin
      step();
      cyc++;
    end
    check("midrst_ready_latency", cyc, DEPTH);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'(i << 2), 0, 0, 0, 0, 0);
      step();
      check($sformatf("sweep_entry%0d", i), int'(bus.pred_counter), 1);
      check_model("sweep");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
